// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: load/run/stop sequencer that streams a program into imem, releases the CPU,
// and ends the run on a retired halt instruction or a cycle limit.
module cpu_run_ctrl #(
   parameter int XLEN = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W = 6,
   parameter int CNT_W = 16,
   parameter int MAX_CYCLES = 200,
   parameter logic [XLEN-1:0] HALT_INSTR = 32'h00100073
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              cpu_reset,
   input  logic              retire_valid,
   input  logic [XLEN-1:0]   retire_instr,
   input  logic [XLEN-1:0]   retire_pc,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  retire_count,
   output logic [XLEN-1:0]   halt_pc,
   output logic              done,
   output logic              timeout,
   output logic              load_overflow
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, TIMEOUT} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] wptr, wptr_n, addr_n;
   logic [XLEN-1:0] wdata_n, hpc_n;
   logic [CNT_W-1:0] cyc_n, ret_n;
   logic ready_n, we_n, cpu_reset_n, done_n, tmo_n, ovf_n, halt, limit;

   assign halt = retire_valid && retire_instr == HALT_INSTR;
   assign limit = cycle_count == CNT_W'(MAX_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wptr <= '0;
         load_ready <= 1'b0;
         imem_we <= 1'b0;
         imem_addr <= '0;
         imem_wdata <= '0;
         cpu_reset <= 1'b1;
         cycle_count <= '0;
         retire_count <= '0;
         halt_pc <= '0;
         done <= 1'b0;
         timeout <= 1'b0;
         load_overflow <= 1'b0;
      end else begin
         state <= state_n;
         wptr <= wptr_n;
         load_ready <= ready_n;
         imem_we <= we_n;
         imem_addr <= addr_n;
         imem_wdata <= wdata_n;
         cpu_reset <= cpu_reset_n;
         cycle_count <= cyc_n;
         retire_count <= ret_n;
         halt_pc <= hpc_n;
         done <= done_n;
         timeout <= tmo_n;
         load_overflow <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      wptr_n = wptr;
      ready_n = load_ready;
      we_n = 1'b0;
      addr_n = imem_addr;
      wdata_n = imem_wdata;
      cpu_reset_n = cpu_reset;
      cyc_n = cycle_count;
      ret_n = retire_count;
      hpc_n = halt_pc;
      done_n = done;
      tmo_n = timeout;
      ovf_n = load_overflow;
      case (state)
         IDLE, DONE, TIMEOUT: if (start) begin
            state_n = LOAD;
            wptr_n = '0;
            ready_n = 1'b1;
            cpu_reset_n = 1'b1;
            cyc_n = '0;
            ret_n = '0;
            hpc_n = '0;
            done_n = 1'b0;
            tmo_n = 1'b0;
            ovf_n = 1'b0;
         end
         // load_ready low inside LOAD means the last write pulse is on the bus now
         LOAD: if (!load_ready) begin
            state_n = RUN;
            cpu_reset_n = 1'b0;
         end else if (load_valid) begin
            we_n = 1'b1;
            addr_n = wptr;
            wdata_n = load_data;
            wptr_n = wptr + 1'b1;
            if (load_last || wptr == ADDR_W'(IMEM_DEPTH - 1)) begin
               ready_n = 1'b0;
               ovf_n = !load_last;
            end
         end
         RUN: begin
            if (retire_valid && retire_count != '1) ret_n = retire_count + 1'b1;
            if (halt) begin
               state_n = DONE;
               hpc_n = retire_pc;
               done_n = 1'b1;
               cpu_reset_n = 1'b1;
            end else if (limit) begin
               state_n = TIMEOUT;
               tmo_n = 1'b1;
               cpu_reset_n = 1'b1;
            end else cyc_n = cycle_count + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
